// File: rtl/usb_fifo_arbiter_pkg.sv
// usb_fifo_arbiter_pkg
//   Shared definitions for the USB data FIFO arbiter: FSM state encoding,
//   producer source IDs, and the packet framing format (header/trailer).
package usb_fifo_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int ID_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_DATA    = 2'd2,
    ST_TRAILER = 2'd3
  } state_e;

  // Producer source IDs as they appear in the header low nibble
  localparam logic [ID_W-1:0] SRC_ACQ    = 4'd0;
  localparam logic [ID_W-1:0] SRC_SWEEP  = 4'd1;
  localparam logic [ID_W-1:0] SRC_SCURVE = 4'd2;
  localparam logic [ID_W-1:0] SRC_ADC    = 4'd3;

  // Framing: header = {tag, source id}; trailer = raw 16-bit word count.
  // The trailer tag is reserved; the count occupies the whole trailer word.
  localparam logic [11:0]       HEADER_TAG_DEF  = 12'hA5C;
  localparam logic [3:0]        TRAILER_TAG_DEF = 4'hE;
  localparam logic [DATA_W-1:0] CNT_MAX         = 16'hFFFF;

  function automatic logic [DATA_W-1:0] make_header(input logic [11:0]     tag,
                                                    input logic [ID_W-1:0] id);
    return {tag, id};
  endfunction

endpackage

// File: rtl/usb_fifo_arbiter_rr_select.sv
// usb_fifo_arbiter_rr_select
//   Combinational round-robin picker: returns the first set bit of elig at or
//   after ptr, searching cyclically modulo NUM_SRC.
//   elig  : eligible requester mask
//   ptr   : search start index (highest-priority position this round)
//   found : at least one requester eligible
//   index : chosen requester (0 when none found)
module usb_fifo_arbiter_rr_select
  import usb_fifo_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] elig,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  // Outer loop walks priority order from ptr; inner loop keeps every bit
  // select constant so the index never needs a variable-width select.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!found && elig[j] && (j == ((int'(ptr) + k) % NUM_SRC))) begin
          found = 1'b1;
          index = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/usb_fifo_arbiter.sv
// usb_fifo_arbiter
//   Shares the 16-bit USB external FIFO write port between NUM_SRC packet
//   producers. One producer is granted at a time (round robin); each packet
//   is framed as {HEADER_TAG, id}, data words..., word count.
//   clk/reset    : system clock, synchronous active-high reset
//   src_enable   : per-source arbitration enable
//   src_valid/src_data/src_last/src_ready : per-source word handshake
//   fifo_full    : FIFO full flag; no write is issued while it is high
//   fifo_wr_en/fifo_wr_din : FIFO write port
//   busy         : packet in progress
//   active_src   : granted source, valid while busy
//   packet_done  : one-cycle pulse in the cycle after the trailer write
module usb_fifo_arbiter
  import usb_fifo_arbiter_pkg::*;
#(
  parameter int          NUM_SRC    = 4,
  parameter logic [11:0] HEADER_TAG = HEADER_TAG_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_enable,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [DATA_W*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_last,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wr_din,
  output logic                      busy,
  output logic [ID_W-1:0]           active_src,
  output logic                      packet_done
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] word_cnt_q, word_cnt_d;
  logic              packet_done_q, packet_done_d;

  logic [NUM_SRC-1:0] gsel;
  logic               g_valid, g_last;
  logic [DATA_W-1:0]  g_data;
  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic               wr;

  // One-hot decode of the grant so the per-source mux uses constant selects
  always_comb begin
    gsel   = '0;
    g_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      gsel[i] = (grant_q == ID_W'(i));
      if (gsel[i]) g_data = src_data[DATA_W*i +: DATA_W];
    end
    g_valid = |(src_valid & gsel);
    g_last  = |(src_last & gsel);
  end

  usb_fifo_arbiter_rr_select #(.NUM_SRC(NUM_SRC)) u_rr_select (
    .elig  (src_valid & src_enable),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .index (pick_idx)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    word_cnt_d    = word_cnt_q;
    packet_done_d = 1'b0;
    src_ready     = '0;
    wr            = 1'b0;
    fifo_wr_din   = '0;
    case (state_q)
      ST_IDLE: begin
        // Grant registered here; header goes out the following cycle
        if (pick_found) begin
          grant_d    = pick_idx;
          word_cnt_d = '0;
          state_d    = ST_HEADER;
        end
      end
      ST_HEADER: begin
        wr          = ~fifo_full;
        fifo_wr_din = make_header(HEADER_TAG, grant_q);
        if (wr) state_d = ST_DATA;
      end
      ST_DATA: begin
        // Zero-latency pass-through from the granted source; src_enable is
        // ignored here so a disabled source still finishes its packet.
        src_ready   = gsel & {NUM_SRC{~fifo_full}};
        wr          = g_valid & ~fifo_full;
        fifo_wr_din = g_data;
        if (wr) begin
          if (word_cnt_q != CNT_MAX) word_cnt_d = word_cnt_q + 16'd1;
          if (g_last) state_d = ST_TRAILER;
        end
      end
      ST_TRAILER: begin
        wr          = ~fifo_full;
        fifo_wr_din = word_cnt_q;
        if (wr) begin
          packet_done_d = 1'b1;
          rr_ptr_d      = (grant_q == ID_W'(NUM_SRC - 1)) ? '0 : grant_q + 4'd1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      word_cnt_q    <= '0;
      packet_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      word_cnt_q    <= word_cnt_d;
      packet_done_q <= packet_done_d;
    end
  end

  assign fifo_wr_en  = wr;
  assign busy        = (state_q != ST_IDLE);
  assign active_src  = grant_q;
  assign packet_done = packet_done_q;

endmodule
